// File: rtl/dst_stream_out.sv
// dst_stream_out: turns output-buffer reads issued by the batch controller
// into an AXI-Stream. Each read returns data one cycle later; that word and
// its "last word of the batch" flag go into a small FIFO whose head entry
// drives the stream. dst_ready reserves room for the read still in flight.
module dst_stream_out #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [11:0]   ds,
    input  logic          dst_v,
    input  logic [11:0]   dst_a,
    output logic          dst_ready,
    input  logic [DW-1:0] rd_data,
    output logic          m_axis_tvalid,
    output logic [DW-1:0] m_axis_tdata,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready,
    output logic          done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    // Each entry is {tlast, tdata}
    logic [DW:0]   fifo_mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] occupancy;
    logic          rd_pend_reg;
    logic          last_q_reg;
    logic          done_reg;
    logic          rd_accept;
    logic          push;
    logic          pop;

    // Occupancy counts the in-flight read so a returning word always has a slot;
    // pops in the current cycle are deliberately not credited.
    assign occupancy     = cnt_reg + CW'(rd_pend_reg);
    assign dst_ready     = occupancy < CW'(DEPTH);

    // A strobe while not ready, or while flushing, is dropped outright.
    assign rd_accept     = run & dst_v & dst_ready;
    assign push          = run & rd_pend_reg;

    assign m_axis_tvalid = (cnt_reg != '0);
    assign pop           = run & m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = fifo_mem_reg[rd_ptr_reg][DW-1:0];
    assign m_axis_tlast  = fifo_mem_reg[rd_ptr_reg][DW];
    assign done          = done_reg;

    // Next FIFO fill level: simultaneous push and pop cancel out.
    always_comb begin
        cnt_next = cnt_reg;
        if (push && !pop) begin
            cnt_next = cnt_reg + CW'(1);
        end else if (pop && !push) begin
            cnt_next = cnt_reg - CW'(1);
        end
    end

    // Control state: read pipeline, pointers, fill level and done pulse; run low flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            rd_pend_reg <= 1'b0;
            last_q_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else if (!run) begin
            cnt_reg     <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            rd_pend_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            rd_pend_reg <= rd_accept;
            if (rd_accept) begin
                last_q_reg <= (dst_a == ds);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            done_reg    <= pop & m_axis_tlast;
        end
    end

    // FIFO storage: written with the returning word; cleared on reset so tdata idles at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_reg[i] <= '0;
            end
        end else if (push) begin
            fifo_mem_reg[wr_ptr_reg] <= {last_q_reg, rd_data};
        end
    end

endmodule

// File: tb/tb_dst_stream_out.sv
// Bench for dst_stream_out: a batch-controller driver and an output-buffer
// model feed the block; every accepted read queues its expected beat, and an
// independent monitor pops and compares each beat the stream delivers.
module tb_dst_stream_out;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic [11:0]   ds = '0;
    logic          dst_v = 1'b0;
    logic [11:0]   dst_a = '0;
    logic [DW-1:0] rd_data = '0;
    logic          m_axis_tready = 1'b0;
    wire           dst_ready;
    wire           m_axis_tvalid;
    wire [DW-1:0]  m_axis_tdata;
    wire           m_axis_tlast;
    wire           done;

    dst_stream_out #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .ds            (ds),
        .dst_v         (dst_v),
        .dst_a         (dst_a),
        .dst_ready     (dst_ready),
        .rd_data       (rd_data),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    logic          done_exp = 1'b0;
    logic [DW-1:0] salt = '0;

    // Contents of the output buffer at a given address for the current batch
    function automatic logic [DW-1:0] mem_val(input logic [11:0] a);
        return 32'h100 + {20'h0, a} + salt;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output buffer: data for the address strobed last cycle; junk otherwise
    initial begin : mem_model
        logic        v;
        logic [11:0] a;
        forever begin
            @(posedge clk);
            v = dst_v;
            a = dst_a;
            #1;
            rd_data = v ? mem_val(a) : DW'($urandom);
        end
    end

    // Monitor: compares each accepted beat with the scoreboard and checks done timing
    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_exp = 1'b0;
            end else begin
                check("done", done, done_exp);
                done_exp = 1'b0;
                if (done) done_cnt++;
                if (run && m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat: got unexpected data %0h, expected no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        $display("beat data=%08h last=%0b", m_axis_tdata, m_axis_tlast);
                        check("tdata", m_axis_tdata, e.d);
                        check("tlast", m_axis_tlast, e.l);
                        if (e.l) done_exp = 1'b1;
                    end
                end
            end
        end
    end

    // One batch: addresses 0..n_last issued in order whenever the block is ready.
    // rmode is the tready percentage, or >100 for tready toggling every cycle.
    // hold keeps tready low for that many cycles and then checks the full state.
    task automatic batch(input int n_last, input int vpct, input int rmode,
                         input int hold, input logic [DW-1:0] s);
        int nxt;
        int cyc;
        int start;
        nxt   = 0;
        cyc   = 0;
        start = done_cnt;
        salt  = s;
        ds    = 12'(n_last);
        run   = 1'b1;
        while ((nxt <= n_last || exp_q.size() != 0 || done_cnt == start) && cyc < 4000) begin
            if (cyc < hold)      m_axis_tready = 1'b0;
            else if (rmode > 100) m_axis_tready = cyc[0];
            else                 m_axis_tready = ($urandom_range(99) < rmode);
            if (nxt <= n_last && dst_ready && $urandom_range(99) < vpct) begin
                dst_v = 1'b1;
                dst_a = 12'(nxt);
                exp_q.push_back('{d: mem_val(12'(nxt)), l: (nxt == n_last)});
                nxt++;
            end else if (!dst_ready && $urandom_range(3) == 0) begin
                dst_v = 1'b1;                 // illegal strobe, must be dropped
                dst_a = 12'($urandom);
            end else begin
                dst_v = 1'b0;
                dst_a = 12'($urandom);
            end
            tick();
            cyc++;
            if (hold > 0 && cyc == hold) begin
                check("hold_dst_ready", dst_ready, 1'b0);
                check("hold_entries", exp_q.size(), DEPTH);
                check("hold_tvalid", m_axis_tvalid, 1'b1);
            end
        end
        dst_v = 1'b0;
        if (cyc >= 4000) begin
            total++;
            bad++;
            $display("FAIL batch_timeout: got %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
        check("done_pulses", done_cnt - start, 1);
        $display("batch ds=%0d finished after %0d cycles", n_last, cyc);
    endtask

    initial begin : stimulus
        int start;

        // Reset state
        #3;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_dst_ready", dst_ready, 1'b1);
        check("rst_done", done, 1'b0);
        #20;
        rst_n = 1'b1;
        tick();

        // Single word: tvalid two cycles after the strobe, with tlast
        salt = '0;
        ds = '0;
        run = 1'b1;
        m_axis_tready = 1'b1;
        start = done_cnt;
        dst_v = 1'b1;
        dst_a = '0;
        exp_q.push_back('{d: mem_val(12'h0), l: 1'b1});
        tick();
        dst_v = 1'b0;
        check("single_n1_tvalid", m_axis_tvalid, 1'b0);
        tick();
        check("single_n2_tvalid", m_axis_tvalid, 1'b1);
        check("single_n2_tlast", m_axis_tlast, 1'b1);
        check("single_n2_tdata", m_axis_tdata, 32'h100);
        repeat (4) tick();
        check("single_done", done_cnt - start, 1);
        check("single_drained", exp_q.size(), 0);

        // Streaming, backpressure, wrap with toggling tready
        batch(7, 100, 100, 0, '0);
        batch(15, 100, 100, 10, DW'($urandom));
        batch(40, 100, 200, 0, DW'($urandom));

        // Flush with three entries queued and one read in flight
        salt = DW'($urandom);
        ds = 12'd7;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dst_v = 1'b1;
            dst_a = 12'(i);
            exp_q.push_back('{d: mem_val(12'(i)), l: 1'b0});
            tick();
        end
        check("flush_pre_ready", dst_ready, 1'b0);
        check("flush_pre_tvalid", m_axis_tvalid, 1'b1);
        run = 1'b0;
        dst_v = 1'b1;
        dst_a = 12'd4;
        m_axis_tready = 1'b1;
        exp_q.delete();
        tick();
        run = 1'b1;
        dst_v = 1'b0;
        check("flush_tvalid", m_axis_tvalid, 1'b0);
        check("flush_dst_ready", dst_ready, 1'b1);
        batch(5, 70, 60, 0, DW'($urandom));

        // Asynchronous reset mid-batch
        salt = DW'($urandom);
        ds = 12'd9;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dst_v = 1'b1;
            dst_a = 12'(i);
            exp_q.push_back('{d: mem_val(12'(i)), l: 1'b0});
            tick();
        end
        dst_v = 1'b0;
        tick();
        check("arst_pre_tvalid", m_axis_tvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 1'b0);
        check("arst_tlast", m_axis_tlast, 1'b0);
        check("arst_tdata", m_axis_tdata, '0);
        check("arst_dst_ready", dst_ready, 1'b1);
        check("arst_done", done, 1'b0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        batch(6, 100, 100, 0, DW'($urandom));

        // Random batches
        for (int b = 0; b < 6; b++) begin
            batch($urandom_range(30, 0), $urandom_range(100, 30),
                  $urandom_range(100, 20), 0, DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
